// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: glitch-free power-of-two clock divider controller.
//
// A single free-running counter in the clk domain generates a divided clock
// (ratio 2^cur_sel) and a matching one-cycle enable. Ratio changes go through
// a four-phase sel_req/sel_ack handshake and are applied only at a period
// boundary, so div_clk never produces a runt phase.
//
// Optional feature macro: CLKDIV_HOLD_EN
//   When defined, adds the 'hold' input and a HOLD state that parks the
//   divider (div_clk low, counter at 0) at a period boundary.
//
// Parameters:
//   CNT_W        counter width; largest ratio is 2^CNT_W
//   DEFAULT_SEL  ratio select after reset (1..CNT_W)
//
// Ports:
//   clk      in   single clock, rising edge
//   reset    in   synchronous active-low reset
//   sel      in   [2:0] requested ratio select (valid 1..CNT_W)
//   sel_req  in   change request, four-phase level
//   hold     in   park request (only with CLKDIV_HOLD_EN)
//   sel_ack  out  change applied, held until sel_req falls
//   sel_err  out  one-cycle pulse for a request with an invalid sel
//   busy     out  high whenever the FSM is not in RUN
//   cur_sel  out  [2:0] ratio select currently in effect
//   div_clk  out  registered divided clock, 50% duty
//   div_en   out  registered pulse in the last clk cycle of each period

module clk_div_ctrl #(
  parameter int CNT_W       = 5,
  parameter int DEFAULT_SEL = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sel,
  input  logic       sel_req,
`ifdef CLKDIV_HOLD_EN
  input  logic       hold,
`endif
  output logic       sel_ack,
  output logic       sel_err,
  output logic       busy,
  output logic [2:0] cur_sel,
  output logic       div_clk,
  output logic       div_en
);

`ifdef CLKDIV_HOLD_EN
  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_ACK, ST_HOLD} state_t;
`else
  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_ACK} state_t;
`endif

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       cur_sel_n;
  logic [2:0]       pend_sel, pend_sel_n;
  logic             sel_ack_n;
  logic             sel_err_n;
  logic             err_block, err_block_n;
  logic             div_clk_n;
  logic             div_en_n;
  logic [CNT_W-1:0] cur_mask;
  logic [CNT_W-1:0] next_mask;
  logic             boundary;
  logic             sel_valid;

  // Low k bits set: the in-period counter value L is (cnt & mask), and the
  // last cycle of a period is where L equals the mask itself.
  function automatic logic [CNT_W-1:0] ratio_mask(input logic [2:0] k);
    logic [CNT_W-1:0] m;
    m = '0;
    for (int i = 0; i < CNT_W; i++) begin
      if (i < int'(k)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Bit k-1 of the counter is exactly a 50% duty clock at ratio 2^k.
  function automatic logic half_bit(input logic [CNT_W-1:0] c, input logic [2:0] k);
    logic b;
    b = 1'b0;
    for (int i = 0; i < CNT_W; i++) begin
      if (i + 1 == int'(k)) b = c[i];
    end
    return b;
  endfunction

  assign cur_mask  = ratio_mask(cur_sel);
  assign boundary  = ((cnt & cur_mask) == cur_mask);
  assign sel_valid = (sel != 3'd0) && (int'(sel) <= CNT_W);
  assign busy      = (state != ST_RUN);

  // State register. div_clk/div_en are loaded from the next-state counter and
  // select so they line up with cnt in the same cycle without a combinational
  // output path.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_RUN;
      cnt       <= '0;
      cur_sel   <= 3'(DEFAULT_SEL);
      pend_sel  <= 3'(DEFAULT_SEL);
      sel_ack   <= 1'b0;
      sel_err   <= 1'b0;
      err_block <= 1'b0;
      div_clk   <= 1'b0;
      div_en    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cur_sel   <= cur_sel_n;
      pend_sel  <= pend_sel_n;
      sel_ack   <= sel_ack_n;
      sel_err   <= sel_err_n;
      err_block <= err_block_n;
      div_clk   <= div_clk_n;
      div_en    <= div_en_n;
    end
  end

  // Next-state logic. The counter free-runs unless a switch or a hold forces
  // it back to 0 so the new period starts with a full low half.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt + CNT_W'(1);
    cur_sel_n   = cur_sel;
    pend_sel_n  = pend_sel;
    sel_ack_n   = sel_ack;
    sel_err_n   = 1'b0;
    err_block_n = err_block;

    case (state)
      ST_RUN: begin
`ifdef CLKDIV_HOLD_EN
        if (hold && boundary) begin
          state_n = ST_HOLD;
          cnt_n   = '0;
        end else
`endif
        if (!sel_req) begin
          err_block_n = 1'b0;
        end else if (!err_block) begin
          // A rejected request stays blocked until sel_req is seen low, so a
          // held-high invalid request yields exactly one error pulse.
          if (sel_valid) begin
            pend_sel_n = sel;
            state_n    = ST_WAIT;
          end else begin
            sel_err_n   = 1'b1;
            err_block_n = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (boundary) begin
          cur_sel_n = pend_sel;
          cnt_n     = '0;
          sel_ack_n = 1'b1;
          state_n   = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!sel_req) begin
          sel_ack_n = 1'b0;
          state_n   = ST_RUN;
        end
      end
`ifdef CLKDIV_HOLD_EN
      ST_HOLD: begin
        cnt_n = '0;
        if (!hold) state_n = ST_RUN;
      end
`endif
      default: begin
        state_n = ST_RUN;
      end
    endcase
  end

  // Output next values follow the counter and select that will be in effect.
  assign next_mask = ratio_mask(cur_sel_n);
  always_comb begin
    div_clk_n = half_bit(cnt_n, cur_sel_n);
    div_en_n  = ((cnt_n & next_mask) == next_mask);
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed testbench for clk_div_ctrl (CNT_W=5, DEFAULT_SEL=1).
// A vector table covers reset, divide-by-2/4 waveforms, a ratio change,
// invalid-select errors and reset mid-period; hand-written sequences cover the
// 2->32 and 32->2 switches, reset during WAIT and (with CLKDIV_HOLD_EN) hold.

module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] sel;
  logic       sel_req;
`ifdef CLKDIV_HOLD_EN
  logic       hold;
`endif
  logic       sel_ack;
  logic       sel_err;
  logic       busy;
  logic [2:0] cur_sel;
  logic       div_clk;
  logic       div_en;

  int errors = 0;
  int checks = 0;

  clk_div_ctrl #(.CNT_W(5), .DEFAULT_SEL(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .sel     (sel),
    .sel_req (sel_req),
`ifdef CLKDIV_HOLD_EN
    .hold    (hold),
`endif
    .sel_ack (sel_ack),
    .sel_err (sel_err),
    .busy    (busy),
    .cur_sel (cur_sel),
    .div_clk (div_clk),
    .div_en  (div_en)
  );

  always #5 clk = ~clk;

  // One vector: inputs applied before a clock edge, outputs expected after it.
  // exp packs {div_clk, div_en, sel_ack, sel_err, busy, cur_sel[2:0]}.
  typedef struct {
    logic       rst;
    logic [2:0] s;
    logic       rq;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [23];

  // Drive inputs, take one rising edge, then settle 1ns past it for sampling.
  task automatic applyStimulus(input logic rst, input logic [2:0] s, input logic rq);
    reset   = rst;
    sel     = s;
    sel_req = rq;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {div_clk, div_en, sel_ack, sel_err, busy, cur_sel};
  endfunction

  initial begin
    logic [7:0] e;
    reset   = 1'b0;
    sel     = 3'd0;
    sel_req = 1'b0;
`ifdef CLKDIV_HOLD_EN
    hold    = 1'b0;
`endif

    //            rst   sel   req   clk  en   ack  err  busy cur
    vecs[0]  = '{1'b0, 3'd0, 1'b0, {1'b0,1'b0,1'b0,1'b0,1'b0,3'd1}};
    vecs[1]  = '{1'b0, 3'd0, 1'b0, {1'b0,1'b0,1'b0,1'b0,1'b0,3'd1}};
    vecs[2]  = '{1'b1, 3'd0, 1'b0, {1'b1,1'b1,1'b0,1'b0,1'b0,3'd1}};
    vecs[3]  = '{1'b1, 3'd0, 1'b0, {1'b0,1'b0,1'b0,1'b0,1'b0,3'd1}};
    vecs[4]  = '{1'b1, 3'd0, 1'b0, {1'b1,1'b1,1'b0,1'b0,1'b0,3'd1}};
    vecs[5]  = '{1'b1, 3'd2, 1'b1, {1'b0,1'b0,1'b0,1'b0,1'b1,3'd1}};
    vecs[6]  = '{1'b1, 3'd2, 1'b1, {1'b1,1'b1,1'b0,1'b0,1'b1,3'd1}};
    vecs[7]  = '{1'b1, 3'd2, 1'b1, {1'b0,1'b0,1'b1,1'b0,1'b1,3'd2}};
    vecs[8]  = '{1'b1, 3'd2, 1'b0, {1'b0,1'b0,1'b0,1'b0,1'b0,3'd2}};
    vecs[9]  = '{1'b1, 3'd2, 1'b0, {1'b1,1'b0,1'b0,1'b0,1'b0,3'd2}};
    vecs[10] = '{1'b1, 3'd2, 1'b0, {1'b1,1'b1,1'b0,1'b0,1'b0,3'd2}};
    vecs[11] = '{1'b1, 3'd2, 1'b0, {1'b0,1'b0,1'b0,1'b0,1'b0,3'd2}};
    vecs[12] = '{1'b1, 3'd7, 1'b1, {1'b0,1'b0,1'b0,1'b1,1'b0,3'd2}};
    vecs[13] = '{1'b1, 3'd7, 1'b1, {1'b1,1'b0,1'b0,1'b0,1'b0,3'd2}};
    vecs[14] = '{1'b1, 3'd3, 1'b1, {1'b1,1'b1,1'b0,1'b0,1'b0,3'd2}};
    vecs[15] = '{1'b1, 3'd3, 1'b0, {1'b0,1'b0,1'b0,1'b0,1'b0,3'd2}};
    vecs[16] = '{1'b1, 3'd0, 1'b1, {1'b0,1'b0,1'b0,1'b1,1'b0,3'd2}};
    vecs[17] = '{1'b1, 3'd0, 1'b0, {1'b1,1'b0,1'b0,1'b0,1'b0,3'd2}};
    vecs[18] = '{1'b1, 3'd2, 1'b1, {1'b1,1'b1,1'b0,1'b0,1'b1,3'd2}};
    vecs[19] = '{1'b1, 3'd2, 1'b1, {1'b0,1'b0,1'b1,1'b0,1'b1,3'd2}};
    vecs[20] = '{1'b1, 3'd2, 1'b1, {1'b0,1'b0,1'b1,1'b0,1'b1,3'd2}};
    vecs[21] = '{1'b1, 3'd2, 1'b0, {1'b1,1'b0,1'b0,1'b0,1'b0,3'd2}};
    vecs[22] = '{1'b0, 3'd2, 1'b0, {1'b0,1'b0,1'b0,1'b0,1'b0,3'd1}};

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].s, vecs[i].rq);
      checkOutput($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Divide-by-2 to divide-by-32: request during cycle 2, ack at cycle 4.
    applyStimulus(1'b1, 3'd0, 1'b0);
    applyStimulus(1'b1, 3'd0, 1'b0);
    applyStimulus(1'b1, 3'd5, 1'b1);
    checkOutput("to32_wait", {5'd0, sel_ack, busy, 1'b0}, {5'd0, 1'b0, 1'b1, 1'b0});
    applyStimulus(1'b1, 3'd5, 1'b1);
    checkOutput("to32_ack", {div_clk, div_en, sel_ack, busy, 1'b0, cur_sel},
                {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5});
    for (int j = 1; j <= 64; j++) begin
      applyStimulus(1'b1, 3'd5, 1'b0);
      e = {5'd0, ((j % 32) >= 16) ? 1'b1 : 1'b0, ((j % 32) == 31) ? 1'b1 : 1'b0,
           (j == 1) ? 1'b0 : sel_ack};
      checkOutput($sformatf("div32_c%0d", j), {5'd0, div_clk, div_en, sel_ack}, e);
    end

    // Divide-by-32 to divide-by-2 requested mid low phase (cnt=10): the old
    // period must run to cnt=31, ack appears 22 edges after the request edge.
    for (int j = 0; j < 10; j++) applyStimulus(1'b1, 3'd5, 1'b0);
    for (int n = 1; n <= 26; n++) begin
      applyStimulus(1'b1, 3'd1, 1'b1);
      if (n <= 21)
        e = {((10 + n) >= 16) ? 1'b1 : 1'b0, (10 + n == 31) ? 1'b1 : 1'b0, 1'b0, 2'd0, 3'd5};
      else
        e = {((n - 22) % 2 == 1) ? 1'b1 : 1'b0, ((n - 22) % 2 == 1) ? 1'b1 : 1'b0,
             1'b1, 2'd0, 3'd1};
      checkOutput($sformatf("to2_n%0d", n), {div_clk, div_en, sel_ack, 2'd0, cur_sel}, e);
    end
    applyStimulus(1'b1, 3'd1, 1'b0);
    checkOutput("to2_release", {6'd0, sel_ack, busy}, 8'd0);

    // Reset asserted while a request is waiting for its boundary.
    applyStimulus(1'b1, 3'd4, 1'b1);
    checkOutput("rstwait_busy", {7'd0, busy}, 8'd1);
    applyStimulus(1'b0, 3'd4, 1'b1);
    checkOutput("rstwait_reset", outs(), {5'b00000, 3'd1});
    applyStimulus(1'b1, 3'd4, 1'b0);
    checkOutput("rstwait_restart", outs(), {5'b11000, 3'd1});

`ifdef CLKDIV_HOLD_EN
    // Switch to divide-by-8, then hold mid-period and request during hold.
    applyStimulus(1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 3'd3, 1'b1);
    applyStimulus(1'b1, 3'd3, 1'b1);
    checkOutput("hold_setup_ack", {sel_ack, 4'd0, cur_sel}, {1'b1, 4'd0, 3'd3});
    applyStimulus(1'b1, 3'd3, 1'b0);
    applyStimulus(1'b1, 3'd3, 1'b0);
    hold = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      if (n >= 7) applyStimulus(1'b1, 3'd2, 1'b1);
      else        applyStimulus(1'b1, 3'd3, 1'b0);
      if (n <= 5) e = {((2 + n) >= 4) ? 1'b1 : 1'b0, 1'b0, 1'b0, 2'b00, 3'd3};
      else        e = {1'b0, 1'b0, 1'b0, 2'b01, 3'd3};
      checkOutput($sformatf("hold_n%0d", n), {div_clk, div_en, sel_ack, 1'b0, busy, cur_sel}, e);
    end
    hold = 1'b0;
    for (int m = 1; m <= 9; m++) begin
      applyStimulus(1'b1, 3'd2, 1'b1);
      e = {(m <= 8 && (m - 1) >= 4) ? 1'b1 : 1'b0, (m == 8) ? 1'b1 : 1'b0,
           (m == 9) ? 1'b1 : 1'b0, 1'b0, (m >= 2) ? 1'b1 : 1'b0,
           (m == 9) ? 3'd2 : 3'd3};
      checkOutput($sformatf("unhold_m%0d", m), {div_clk, div_en, sel_ack, 1'b0, busy, cur_sel}, e);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
